// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - shared types and helpers for Johnson-code consumers
package johnson_pkg;

  // Sequence-checker FSM state
  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_e;

  // Relationship of a new sample to the previous legal index
  typedef enum logic [1:0] {
    CLS_HOLD    = 2'd0,
    CLS_ADV     = 2'd1,
    CLS_JUMP    = 2'd2,
    CLS_ILLEGAL = 2'd3
  } cls_e;

  // Index width for an N-bit Johnson register (2N states)
  function automatic int idx_w(input int n);
    return $clog2(2 * n);
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// rtl/johnson_decode.sv - combinational Johnson code legality check and index decode
module johnson_decode
  import johnson_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          code,
  output logic [idx_w(N)-1:0]   idx,
  output logic                  legal
);

  localparam int IDX_W = idx_w(N);

  // Legal codes have at most one 0/1 boundary; index follows the fill/drain of ones
  always_comb begin
    int trans;
    int pop;
    trans = 0;
    pop   = 0;
    for (int i = 0; i < N - 1; i++) begin
      if (code[i] != code[i+1]) trans = trans + 1;
    end
    for (int i = 0; i < N; i++) begin
      pop = pop + int'(code[i]);
    end
    legal = (trans <= 1);
    if (code[N-1]) idx = IDX_W'(2 * N - pop);
    else           idx = IDX_W'(pop);
  end

endmodule

// File: rtl/johnson_rx_monitor.sv
// rtl/johnson_rx_monitor.sv - Johnson bus sampler with legality, lock and sequence-error tracking
module johnson_rx_monitor
  import johnson_pkg::*;
#(
  parameter int N        = 4,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 en,
  input  logic [N-1:0]         j_in,
  input  logic                 err_clr,
  output logic [idx_w(N)-1:0]  idx,
  output logic                 legal,
  output logic                 locked,
  output logic                 step,
  output logic                 wrap,
  output logic                 err,
  output logic [ERR_W-1:0]     err_cnt
);

  localparam int IDX_W = idx_w(N);
  localparam int RUN_W = $clog2(LOCK_CNT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * N - 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_CNT - 1);

  logic [N-1:0]     j_q;
  logic             s_valid;
  logic [IDX_W-1:0] dec_idx;
  logic             dec_legal;
  logic             prev_valid;
  logic [IDX_W-1:0] next_idx;
  cls_e             cls;
  state_e           state, state_next;
  logic [RUN_W-1:0] run, run_next;
  logic             step_d, wrap_d, err_d;

  johnson_decode #(.N(N)) u_decode (
    .code  (j_q),
    .idx   (dec_idx),
    .legal (dec_legal)
  );

  // Input capture stage; s_valid marks a sample waiting to be evaluated
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      j_q     <= '0;
      s_valid <= 1'b0;
    end else begin
      s_valid <= en;
      if (en) j_q <= j_in;
    end
  end

  // idx register doubles as the previous legal index
  assign next_idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;

  // Classify the captured sample against the previous legal index
  always_comb begin
    cls = CLS_JUMP;
    if (!dec_legal)             cls = CLS_ILLEGAL;
    else if (!prev_valid)       cls = CLS_JUMP;
    else if (dec_idx == idx)    cls = CLS_HOLD;
    else if (dec_idx == next_idx) cls = CLS_ADV;
  end

  // FSM state and lock-run register
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state <= UNLOCKED;
      run   <= '0;
    end else begin
      state <= state_next;
      run   <= run_next;
    end
  end

  // Next state: count consecutive advances to lock, drop lock on any break
  always_comb begin
    state_next = state;
    run_next   = run;
    if (s_valid) begin
      case (state)
        UNLOCKED: begin
          case (cls)
            CLS_ADV: begin
              if (run == RUN_LAST) begin
                state_next = LOCKED;
                run_next   = '0;
              end else begin
                run_next = run + 1'b1;
              end
            end
            CLS_HOLD: run_next = run;
            default:  run_next = '0;
          endcase
        end
        default: begin
          if (cls == CLS_JUMP || cls == CLS_ILLEGAL) begin
            state_next = UNLOCKED;
            run_next   = '0;
          end
        end
      endcase
    end
  end

  // Pulse decode: only meaningful while LOCKED and a sample is being evaluated
  always_comb begin
    step_d = s_valid && (state == LOCKED) && (cls == CLS_ADV);
    wrap_d = step_d && (idx == LAST_IDX);
    err_d  = s_valid && (state == LOCKED) && (cls == CLS_JUMP || cls == CLS_ILLEGAL);
  end

  assign locked = (state == LOCKED);

  // Registered outputs, previous-sample tracking and saturating error count
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      idx        <= '0;
      legal      <= 1'b0;
      prev_valid <= 1'b0;
      step       <= 1'b0;
      wrap       <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= '0;
    end else begin
      step <= step_d;
      wrap <= wrap_d;
      err  <= err_d;
      if (s_valid) begin
        legal      <= dec_legal;
        prev_valid <= dec_legal;
        if (dec_legal) idx <= dec_idx;
      end
      if (err_clr)                    err_cnt <= '0;
      else if (err_d && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_johnson_rx_monitor.sv
// tb/tb_johnson_rx_monitor.sv - directed self-checking bench for johnson_rx_monitor
module tb_johnson_rx_monitor;

  logic       clk = 1'b0;
  logic       clear;
  logic       en;
  logic [3:0] j_in;
  logic       err_clr;
  logic [2:0] idx;
  logic       legal, locked, step, wrap, err;
  logic [1:0] err_cnt;

  int checks   = 0;
  int failures = 0;

  johnson_rx_monitor #(.N(4), .LOCK_CNT(3), .ERR_W(2)) dut (
    .clk     (clk),
    .clear   (clear),
    .en      (en),
    .j_in    (j_in),
    .err_clr (err_clr),
    .idx     (idx),
    .legal   (legal),
    .locked  (locked),
    .step    (step),
    .wrap    (wrap),
    .err     (err),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One sample: captured at the next edge, evaluated at the following edge, checked at the negedge after
  task automatic vec(input string tag, input logic [3:0] code, input logic clr,
                     input int e_idx, input int e_legal, input int e_locked,
                     input int e_step, input int e_wrap, input int e_err, input int e_cnt);
    en   = 1'b1;
    j_in = code;
    @(negedge clk);
    en      = 1'b0;
    err_clr = clr;
    @(negedge clk);
    err_clr = 1'b0;
    check_eq({tag, ".idx"},     32'(idx),     32'(e_idx));
    check_eq({tag, ".legal"},   32'(legal),   32'(e_legal));
    check_eq({tag, ".locked"},  32'(locked),  32'(e_locked));
    check_eq({tag, ".step"},    32'(step),    32'(e_step));
    check_eq({tag, ".wrap"},    32'(wrap),    32'(e_wrap));
    check_eq({tag, ".err"},     32'(err),     32'(e_err));
    check_eq({tag, ".err_cnt"}, 32'(err_cnt), 32'(e_cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clear = 1'b1; en = 1'b1; j_in = 4'b0111; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst.idx",     32'(idx),     0);
    check_eq("rst.legal",   32'(legal),   0);
    check_eq("rst.locked",  32'(locked),  0);
    check_eq("rst.err_cnt", 32'(err_cnt), 0);
    clear = 1'b0; en = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle.legal", 32'(legal), 0);
    check_eq("idle.idx",   32'(idx),   0);

    // Latency: captured but not yet evaluated after one edge
    en = 1'b1; j_in = 4'b0000;
    @(negedge clk);
    en = 1'b0;
    check_eq("lat.legal_pending", 32'(legal), 0);
    @(negedge clk);
    check_eq("lat.legal", 32'(legal),  1);
    check_eq("lat.idx",   32'(idx),    0);
    check_eq("lat.lock",  32'(locked), 0);

    //      tag    code     clr  idx lg lk st wr er cnt
    vec("a1", 4'b0001, 1'b0, 1, 1, 0, 0, 0, 0, 0);
    vec("a2", 4'b0011, 1'b0, 2, 1, 0, 0, 0, 0, 0);
    vec("a3", 4'b0111, 1'b0, 3, 1, 1, 0, 0, 0, 0);
    vec("w1", 4'b1111, 1'b0, 4, 1, 1, 1, 0, 0, 0);
    vec("w2", 4'b1110, 1'b0, 5, 1, 1, 1, 0, 0, 0);
    vec("w3", 4'b1100, 1'b0, 6, 1, 1, 1, 0, 0, 0);
    vec("w4", 4'b1000, 1'b0, 7, 1, 1, 1, 0, 0, 0);
    vec("w5", 4'b0000, 1'b0, 0, 1, 1, 1, 1, 0, 0);
    vec("h1", 4'b0000, 1'b0, 0, 1, 1, 0, 0, 0, 0);
    vec("h2", 4'b0000, 1'b0, 0, 1, 1, 0, 0, 0, 0);
    vec("h3", 4'b0000, 1'b0, 0, 1, 1, 0, 0, 0, 0);
    // Illegal code while locked
    vec("i0", 4'b0001, 1'b0, 1, 1, 1, 1, 0, 0, 0);
    vec("i1", 4'b0011, 1'b0, 2, 1, 1, 1, 0, 0, 0);
    vec("i2", 4'b0101, 1'b0, 2, 0, 0, 0, 0, 1, 1);
    vec("r1", 4'b0011, 1'b0, 2, 1, 0, 0, 0, 0, 1);
    vec("r2", 4'b0111, 1'b0, 3, 1, 0, 0, 0, 0, 1);
    vec("r3", 4'b1111, 1'b0, 4, 1, 0, 0, 0, 0, 1);
    vec("r4", 4'b1110, 1'b0, 5, 1, 1, 0, 0, 0, 1);
    // Skip forward from 2 to 4
    vec("s1", 4'b1100, 1'b0, 6, 1, 1, 1, 0, 0, 1);
    vec("s2", 4'b1000, 1'b0, 7, 1, 1, 1, 0, 0, 1);
    vec("s3", 4'b0000, 1'b0, 0, 1, 1, 1, 1, 0, 1);
    vec("s4", 4'b0001, 1'b0, 1, 1, 1, 1, 0, 0, 1);
    vec("s5", 4'b0011, 1'b0, 2, 1, 1, 1, 0, 0, 1);
    vec("k1", 4'b1111, 1'b0, 4, 1, 0, 0, 0, 1, 2);
    // Relock then step backward 3 -> 2
    vec("q1", 4'b1110, 1'b0, 5, 1, 0, 0, 0, 0, 2);
    vec("q2", 4'b1100, 1'b0, 6, 1, 0, 0, 0, 0, 2);
    vec("q3", 4'b1000, 1'b0, 7, 1, 1, 0, 0, 0, 2);
    vec("q4", 4'b0000, 1'b0, 0, 1, 1, 1, 1, 0, 2);
    vec("q5", 4'b0001, 1'b0, 1, 1, 1, 1, 0, 0, 2);
    vec("q6", 4'b0011, 1'b0, 2, 1, 1, 1, 0, 0, 2);
    vec("q7", 4'b0111, 1'b0, 3, 1, 1, 1, 0, 0, 2);
    vec("b1", 4'b0011, 1'b0, 2, 1, 0, 0, 0, 1, 3);
    // Saturation at 3 (fourth and fifth errors)
    vec("t1", 4'b0111, 1'b0, 3, 1, 0, 0, 0, 0, 3);
    vec("t2", 4'b1111, 1'b0, 4, 1, 0, 0, 0, 0, 3);
    vec("t3", 4'b1110, 1'b0, 5, 1, 1, 0, 0, 0, 3);
    vec("t4", 4'b0101, 1'b0, 5, 0, 0, 0, 0, 1, 3);
    vec("u1", 4'b0011, 1'b0, 2, 1, 0, 0, 0, 0, 3);
    vec("u2", 4'b0111, 1'b0, 3, 1, 0, 0, 0, 0, 3);
    vec("u3", 4'b1111, 1'b0, 4, 1, 0, 0, 0, 0, 3);
    vec("u4", 4'b1110, 1'b0, 5, 1, 1, 0, 0, 0, 3);
    vec("u5", 4'b0000, 1'b0, 0, 1, 0, 0, 0, 1, 3);
    // err_clr coinciding with an error
    vec("c1", 4'b0001, 1'b0, 1, 1, 0, 0, 0, 0, 3);
    vec("c2", 4'b0011, 1'b0, 2, 1, 0, 0, 0, 0, 3);
    vec("c3", 4'b0111, 1'b0, 3, 1, 1, 0, 0, 0, 3);
    vec("c4", 4'b1010, 1'b1, 3, 0, 0, 0, 0, 1, 0);
    // Relock, then asynchronous clear between clock edges
    vec("d1", 4'b0111, 1'b0, 3, 1, 0, 0, 0, 0, 0);
    vec("d2", 4'b1111, 1'b0, 4, 1, 0, 0, 0, 0, 0);
    vec("d3", 4'b1110, 1'b0, 5, 1, 0, 0, 0, 0, 0);
    vec("d4", 4'b1100, 1'b0, 6, 1, 1, 0, 0, 0, 0);
    #2 clear = 1'b1;
    #1;
    check_eq("aclr.locked", 32'(locked), 0);
    check_eq("aclr.idx",    32'(idx),    0);
    check_eq("aclr.legal",  32'(legal),  0);
    clear = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
